// File: rtl/snes_pkg.sv
// snes_pkg: shared state encoding, SNES button indices and frame-length helper
package snes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH_HI,
        ST_LATCH_LO,
        ST_CLK_LO,
        ST_CLK_HI,
        ST_COMMIT,
        ST_WAIT
    } state_t;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    // Cycles from latch rise to the frame_done pulse
    function automatic int frame_len(input int bits, input int half_per);
        return 3 * half_per + 2 * bits * half_per + 1;
    endfunction

endpackage

// File: rtl/snes_debounce.sv
// snes_debounce: per-pad debounce, committed button word and edge pulses
module snes_debounce #(
    parameter int BITS     = 16,
    parameter int DEBOUNCE = 2
) (
    input  logic            clk_50,
    input  logic            reset,
    input  logic            commit,
    input  logic [BITS-1:0] raw,
    output logic [BITS-1:0] buttons,
    output logic [BITS-1:0] pressed,
    output logic [BITS-1:0] released
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] TOP = CW'(DEBOUNCE - 1);

    logic [BITS-1:0] last_raw, next_btn;
    logic [CW-1:0]   cnt, next_cnt;

    // Saturating run-length of identical frames; commit once the run is long enough
    always_comb begin
        next_cnt = (raw != last_raw) ? '0 : (cnt == TOP) ? cnt : cnt + 1'b1;
        next_btn = (next_cnt == TOP) ? raw : buttons;
    end

    // State updates only on the commit strobe; edge pulses last exactly that one cycle
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            last_raw <= '0;
            buttons  <= '0;
            pressed  <= '0;
            released <= '0;
        end else begin
            pressed  <= commit ? (next_btn & ~buttons) : '0;
            released <= commit ? (buttons & ~next_btn) : '0;
            if (commit) begin
                cnt      <= next_cnt;
                last_raw <= raw;
                buttons  <= next_btn;
            end
        end
    end

endmodule

// File: rtl/snes_multipad_reader.sv
// snes_multipad_reader: polls several serial SNES/NES pads on shared latch/clock lines
module snes_multipad_reader import snes_pkg::*; #(
    parameter int NUM_PADS     = 2,
    parameter int BITS         = 16,
    parameter int HALF_PER     = 300,
    parameter int UPDATE_DELAY = 30000,
    parameter int AUTO_POLL    = 1,
    parameter int DEBOUNCE     = 2
) (
    input  logic                     clk_50,
    input  logic                     reset,
    input  logic [NUM_PADS-1:0]      controller_dout,
    input  logic                     poll_req,
    output logic                     controller_latch,
    output logic                     controller_clk,
    output logic                     busy,
    output logic                     frame_done,
    output logic [NUM_PADS*BITS-1:0] buttons,
    output logic [NUM_PADS*BITS-1:0] pressed,
    output logic [NUM_PADS*BITS-1:0] released
);

    localparam int CMAX = (2 * HALF_PER > UPDATE_DELAY) ? 2 * HALF_PER : UPDATE_DELAY;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [CW-1:0] HP1  = CW'(HALF_PER - 1);
    localparam logic [CW-1:0] LH1  = CW'(2 * HALF_PER - 1);
    localparam logic [CW-1:0] WD1  = CW'(UPDATE_DELAY - 1);
    localparam logic [BW-1:0] LAST = BW'(BITS - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   bit_idx;
    logic [BITS-1:0] shift [NUM_PADS];
    logic            sample, commit;

    // Pads hold data steady while the clock is low; sample once at CLK_LO entry
    assign sample = (state == ST_CLK_LO) && (cnt == HP1);
    assign commit = (state == ST_COMMIT);

    // Frame sequencer: every phase counts down from N-1 and moves on at zero
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            bit_idx          <= '0;
            controller_latch <= 1'b0;
            controller_clk   <= 1'b1;
            busy             <= 1'b0;
            frame_done       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                case (state)
                    ST_IDLE: if (AUTO_POLL != 0 || poll_req) begin
                        state            <= ST_LATCH_HI;
                        cnt              <= LH1;
                        controller_latch <= 1'b1;
                        busy             <= 1'b1;
                    end
                    ST_LATCH_HI: begin
                        state            <= ST_LATCH_LO;
                        cnt              <= HP1;
                        controller_latch <= 1'b0;
                    end
                    ST_LATCH_LO: begin
                        state          <= ST_CLK_LO;
                        cnt            <= HP1;
                        bit_idx        <= '0;
                        controller_clk <= 1'b0;
                    end
                    ST_CLK_LO: begin
                        state          <= ST_CLK_HI;
                        cnt            <= HP1;
                        controller_clk <= 1'b1;
                    end
                    ST_CLK_HI: if (bit_idx == LAST) begin
                        state <= ST_COMMIT;
                    end else begin
                        state          <= ST_CLK_LO;
                        cnt            <= HP1;
                        bit_idx        <= bit_idx + 1'b1;
                        controller_clk <= 1'b0;
                    end
                    ST_COMMIT: begin
                        state      <= ST_WAIT;
                        cnt        <= WD1;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Per-pad shift capture; data lines are active-low so store the inverse
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PADS; p++) shift[p] <= '0;
        end else if (sample) begin
            for (int p = 0; p < NUM_PADS; p++) shift[p][bit_idx] <= ~controller_dout[p];
        end
    end

    for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
        snes_debounce #(.BITS(BITS), .DEBOUNCE(DEBOUNCE)) u_db (
            .clk_50   (clk_50),
            .reset    (reset),
            .commit   (commit),
            .raw      (shift[g]),
            .buttons  (buttons[g*BITS +: BITS]),
            .pressed  (pressed[g*BITS +: BITS]),
            .released (released[g*BITS +: BITS])
        );
    end

endmodule

// File: tb/tb_snes_multipad_reader.sv
// tb_snes_multipad_reader: directed checks of two reader configurations against pad models
module tb_snes_multipad_reader;
    import snes_pkg::*;

    logic        clk_50 = 1'b0;
    logic        rst_a = 1'b1, rst_b = 1'b1;
    logic        poll_b = 1'b0;
    logic [1:0]  dout_a, dout_b;
    logic        latch_a, clk_a, busy_a, fd_a;
    logic        latch_b, clk_b, busy_b, fd_b;
    logic [31:0] btn_a, prs_a, rel_a, btn_b, prs_b, rel_b;
    logic [15:0] pad_a [2];
    logic [15:0] pad_b [2];
    logic [15:0] sa [2];
    logic [15:0] sb [2];
    int          total = 0, bad = 0;
    int          n_lat_b = 0, n_fd_b = 0;
    int          lat_hi, pulses, min_low, max_low, fd_dly, falls;
    bit          ok, prev;

    always #5 clk_50 = ~clk_50;

    snes_multipad_reader #(.NUM_PADS(2), .BITS(16), .HALF_PER(3), .UPDATE_DELAY(5),
                           .AUTO_POLL(1), .DEBOUNCE(1)) u_a (
        .clk_50(clk_50), .reset(rst_a), .controller_dout(dout_a), .poll_req(1'b0),
        .controller_latch(latch_a), .controller_clk(clk_a), .busy(busy_a), .frame_done(fd_a),
        .buttons(btn_a), .pressed(prs_a), .released(rel_a));

    snes_multipad_reader #(.NUM_PADS(2), .BITS(16), .HALF_PER(3), .UPDATE_DELAY(5),
                           .AUTO_POLL(0), .DEBOUNCE(2)) u_b (
        .clk_50(clk_50), .reset(rst_b), .controller_dout(dout_b), .poll_req(poll_b),
        .controller_latch(latch_b), .controller_clk(clk_b), .busy(busy_b), .frame_done(fd_b),
        .buttons(btn_b), .pressed(prs_b), .released(rel_b));

    // 4021-style pad models: load on latch rise, shift toward bit 0 on clock rise
    initial for (int p = 0; p < 2; p++) begin sa[p] = '1; sb[p] = '1; end
    always @(posedge latch_a or posedge clk_a)
        for (int p = 0; p < 2; p++) sa[p] = latch_a ? pad_a[p] : {1'b1, sa[p][15:1]};
    always @(posedge latch_b or posedge clk_b)
        for (int p = 0; p < 2; p++) sb[p] = latch_b ? pad_b[p] : {1'b1, sb[p][15:1]};
    assign dout_a = {sa[1][0], sa[0][0]};
    assign dout_b = {sb[1][0], sb[0][0]};

    always @(posedge latch_b) if (!rst_b) n_lat_b++;
    always @(posedge clk_50) if (fd_b === 1'b1) n_fd_b++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_50);
        #1;
    endtask

    // Wait for latch rise on DUT A, then profile the frame up to frame_done
    task automatic measure_a;
        int run;
        lat_hi = 0; pulses = 0; min_low = 999; max_low = 0; fd_dly = -1; run = 0;
        for (int i = 0; i < 50 && latch_a !== 1'b1; i++) tick;
        for (int t = 0; t < 400; t++) begin
            if (fd_a === 1'b1) begin fd_dly = t; break; end
            if (latch_a) lat_hi++;
            if (!clk_a) run++;
            else if (run > 0) begin
                pulses++;
                if (run < min_low) min_low = run;
                if (run > max_low) max_low = run;
                run = 0;
            end
            tick;
        end
    endtask

    task automatic wait_fd_b;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick;
            if (fd_b === 1'b1) begin ok = 1'b1; break; end
        end
        check("b_frame_done_seen", {31'b0, ok}, 32'd1);
    endtask

    task automatic poll_frame_b(input logic [15:0] p0, input logic [15:0] p1);
        pad_b[0] = p0;
        pad_b[1] = p1;
        repeat (8) tick;
        poll_b = 1'b1;
        tick;
        poll_b = 1'b0;
        wait_fd_b;
    endtask

    initial begin
        pad_a[0] = 16'hFFFE;
        pad_a[1] = 16'hFFFF;
        pad_b[0] = 16'hFFFF;
        pad_b[1] = 16'hFFFF;
        repeat (3) tick;
        check("rst_latch", {31'b0, latch_a}, 32'd0);
        check("rst_clk", {31'b0, clk_a}, 32'd1);
        check("rst_busy", {31'b0, busy_a}, 32'd0);
        check("rst_fd", {31'b0, fd_a}, 32'd0);
        check("rst_buttons", btn_a, 32'd0);

        // Free-running frame timing plus single B press with no debounce
        rst_a = 1'b0;
        measure_a;
        check("a_latch_hi_len", lat_hi, 32'd6);
        check("a_clk_pulses", pulses, 32'd16);
        check("a_clk_low_min", min_low, 32'd3);
        check("a_clk_low_max", max_low, 32'd3);
        check("a_frame_len", fd_dly, frame_len(16, 3));
        check("a_busy_at_fd", {31'b0, busy_a}, 32'd0);
        check("a_buttons_f1", btn_a, 32'h0000_0001);
        check("a_pressed_f1", prs_a, 32'h0000_0001);
        check("a_released_f1", rel_a, 32'd0);
        tick;
        check("a_pressed_gone", prs_a, 32'd0);
        check("a_fd_gone", {31'b0, fd_a}, 32'd0);
        measure_a;
        check("a_frame2_len", fd_dly, frame_len(16, 3));
        check("a_buttons_f2", btn_a, 32'h0000_0001);
        check("a_pressed_f2", prs_a, 32'd0);

        // Async reset in the middle of bit 7, then a clean restart
        falls = 0;
        prev = 1'b1;
        for (int i = 0; i < 400 && falls < 8; i++) begin
            tick;
            if (prev && !clk_a) falls++;
            prev = clk_a;
        end
        check("a_reach_bit7", falls, 32'd8);
        #2 rst_a = 1'b1;
        #1;
        check("a_midrst_latch", {31'b0, latch_a}, 32'd0);
        check("a_midrst_clk", {31'b0, clk_a}, 32'd1);
        check("a_midrst_busy", {31'b0, busy_a}, 32'd0);
        check("a_midrst_buttons", btn_a, 32'd0);
        repeat (3) tick;
        rst_a = 1'b0;
        measure_a;
        check("a_restart_latch_hi", lat_hi, 32'd6);
        check("a_restart_pulses", pulses, 32'd16);
        check("a_restart_len", fd_dly, frame_len(16, 3));
        check("a_restart_buttons", btn_a, 32'h0000_0001);
        check("a_restart_pressed", prs_a, 32'h0000_0001);

        // On-demand polling: silent until requested, extra requests dropped
        rst_b = 1'b0;
        repeat (150) tick;
        check("b_no_poll_latch", n_lat_b, 32'd0);
        poll_b = 1'b1;
        tick;
        poll_b = 1'b0;
        repeat (20) tick;
        check("b_busy_mid", {31'b0, busy_b}, 32'd1);
        poll_b = 1'b1;
        tick;
        poll_b = 1'b0;
        wait_fd_b;
        check("b_busy_at_fd", {31'b0, busy_b}, 32'd0);
        check("b_buttons_idle", btn_b, 32'd0);
        tick;
        poll_b = 1'b1;
        tick;
        poll_b = 1'b0;
        repeat (200) tick;
        check("b_one_latch", n_lat_b, 32'd1);
        check("b_one_frame", n_fd_b, 32'd1);

        // Debounce: a one-frame blip of A is ignored, two frames commit
        poll_frame_b(16'hFEFF, 16'hFFFF);
        check("b_blip_buttons", btn_b, 32'd0);
        poll_frame_b(16'hFFFF, 16'hFFFF);
        check("b_blip_gone", btn_b, 32'd0);
        poll_frame_b(16'hFEFF, 16'hFFFF);
        check("b_hold1_buttons", btn_b, 32'd0);
        check("b_hold1_pressed", prs_b, 32'd0);
        poll_frame_b(16'hFEFF, 16'hFFFF);
        check("b_hold2_buttons", btn_b, 32'h0000_0100);
        check("b_hold2_pressed", prs_b, 32'h0000_0100);
        tick;
        check("b_pressed_pulse", prs_b, 32'd0);

        // Release A while pad 1 presses its top bit; both commit after two frames
        poll_frame_b(16'hFFFF, 16'h7FFF);
        check("b_rel1_buttons", btn_b, 32'h0000_0100);
        check("b_rel1_released", rel_b, 32'd0);
        poll_frame_b(16'hFFFF, 16'h7FFF);
        check("b_rel2_buttons", btn_b, 32'h8000_0000);
        check("b_rel2_released", rel_b, 32'h0000_0100);
        check("b_rel2_pressed", prs_b, 32'h8000_0000);
        tick;
        check("b_released_pulse", rel_b, 32'd0);
        check("b_frames_total", n_fd_b, 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
